sa_fifo_uart_tx: RTL and testbench
==================================

Name: sa_fifo_uart_tx

Overview:
Reader-side consumer for the show-ahead single-clock FIFO (sa_sc_fifo). It pops words from the FIFO's show-ahead output and serialises each word onto a single line as an asynchronous serial frame. The frame is one start bit, DataWidth data bits LSB first, and StopBits stop bits. It sits directly on the FIFO's read port and drives its ack.

Parameters:
- DataWidth, 8, word width; must equal the FIFO DataWidth.
- ClkDiv, 16, clock cycles per serial bit; legal range >= 2.
- StopBits, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear; shared with the FIFO sclr.
- en  in  1  transmit enable; gates only the start of new frames.
- empty  in  1  FIFO empty flag.
- q  in  DataWidth  FIFO show-ahead data; valid whenever empty=0.
- ack  out  1  FIFO read acknowledge (pop); combinational.
- txd  out  1  serial line, registered; idle level 1.
- busy  out  1  frame in progress.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values (rst_n=0, applied immediately):
  - state=IDLE, txd=1, busy=0.
  - Baud counter and bit counter = 0.
  - ack forced to 0 regardless of empty.
- FSM states are IDLE, START, DATA, STOP.
- ack equals (state==IDLE) & en & !empty & !sclr & rst_n. It is never high for more than one consecutive cycle.
- IDLE, on a rising edge where ack=1:
  - shift register <= q.
  - txd <= 0.
  - baud counter <= 0.
  - state -> START.
  - This matches the FIFO pop at the same edge, so the word is captured with zero extra latency.
- Every non-IDLE state holds its txd value for exactly ClkDiv cycles. A bit period ends when the baud counter reaches ClkDiv-1; the counter then wraps to 0.
- START, at end of bit: txd <= shreg[0], state -> DATA, bit counter <= 0.
- DATA, at end of bit:
  - If bit counter < DataWidth-1: shift right, txd <= next LSB, bit counter +1.
  - Otherwise: txd <= 1, state -> STOP.
- STOP: lasts StopBits*ClkDiv cycles; at the end, state -> IDLE with txd held at 1.
- Frame length is (1+DataWidth+StopBits)*ClkDiv cycles.
- IDLE always lasts at least one cycle, so back-to-back frames have a start-to-start period of (1+DataWidth+StopBits)*ClkDiv + 1 cycles.
- busy = (state != IDLE). It rises on the edge after the ack cycle and falls on the edge ending the last stop bit.
- sclr=1 at a rising edge:
  - state -> IDLE, txd <= 1, counters <= 0.
  - Any frame in flight is aborted mid-bit.
  - ack is held 0 during the sclr cycle, so no word is lost between FIFO and block.
- Clearing en mid-frame does not affect the current frame; it only prevents the next ack.
- Asserting rst_n mid-frame gives the same result as sclr, but takes effect asynchronously.
- Counter widths:
  - Baud counter: $clog2(ClkDiv*StopBits) bits, so the STOP phase can be counted in one run.
  - Bit counter: $clog2(DataWidth) bits.
  - No overflow is permitted; the counters wrap only by explicit reload.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (tx_state_t);
  - a function frame_cycles(DataWidth, ClkDiv, StopBits) used by both RTL assertions and the bench.
- The bench data types reuse tb_fifo_pkg.
- One natural sub-module: baud_gen. It is a restartable modulo-N tick counter with inputs clk, rst_n, restart and output tick, instantiated once.
- Parameter sanity checks are elaboration-time assertions in the top module.

Test Plan:
All scenarios use DataWidth=8, ClkDiv=4, StopBits=1, with the sa_sc_fifo instantiated upstream and a cycle-accurate serial golden decoder checking txd.
1. Reset with FIFO empty, en=1, for 20 cycles -> txd=1, busy=0, ack=0 on every cycle.
2. Write 0xA5, en=1 -> ack high exactly 1 cycle. Then txd runs 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level for 4 cycles. busy is high for 40 cycles and empty returns to 1.
3. Write 0x00 then 0xFF back-to-back -> the two acks are 41 cycles apart. The decoder receives 0x00 then 0xFF, and txd=1 for 5 cycles between the second start bit and the last data-0 bit.
4. Frame with 0x3C; sclr=1 for 1 cycle at frame cycle 15 -> txd=1 and busy=0 on the next cycle. ack=0 during the sclr cycle, no further txd edges occur, and the FIFO reports empty.
5. FIFO holding 0x12 with en=0 for 10 cycles -> ack=0 and txd=1 throughout. Raise en -> ack in the same cycle. Drop en at frame cycle 8 -> the frame still completes and decodes to 0x12.
6. rst_n pulled low at frame cycle 22 -> txd=1 and busy=0 before the next rising edge. After release, the remaining FIFO words transmit correctly. Follow with 1000 random FIFO writes with random en/sclr; every decoded word must match the golden FIFO order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
package uart_pkg;

  // Transmitter phases: idle line, start bit, data bits, stop bit(s).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles from the first start-bit cycle to the end of the last stop bit.
  function automatic int frame_cycles(input int data_width, input int clk_div,
                                      input int stop_bits);
    return (1 + data_width + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/sa_fifo_uart_tx_baud_gen.sv
// Restartable modulo-(limit+1) tick counter that times the serial bit periods.
module baud_gen #(
  parameter int CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic [CntW-1:0] limit,
  output logic            tick
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The period ends on the cycle where the count sits at its limit.
  assign tick = (cnt_q == limit);

  // Next count: wrap on tick, hold at zero while restart is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sa_fifo_uart_tx.sv
// Serialises words popped from a show-ahead FIFO into start/data/stop frames.
module sa_fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 16,
  parameter int StopBits  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic                 en,
  input  logic                 empty,
  input  logic [DataWidth-1:0] q,
  output logic                 ack,
  output logic                 txd,
  output logic                 busy
);

  // Baud counter is wide enough to time the whole stop phase in one run.
  localparam int BaudW = $clog2(ClkDiv * StopBits);
  localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [BaudW-1:0] BitLimit  = BaudW'(ClkDiv - 1);
  localparam logic [BaudW-1:0] StopLimit = BaudW'(ClkDiv * StopBits - 1);
  localparam logic [BitW-1:0]  LastBit   = BitW'(DataWidth - 1);

  if (ClkDiv < 2) begin : g_bad_clk_div
    $error("sa_fifo_uart_tx: ClkDiv must be at least 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
    $error("sa_fifo_uart_tx: StopBits must be 1 or 2");
  end
  if (DataWidth < 1) begin : g_bad_data_width
    $error("sa_fifo_uart_tx: DataWidth must be at least 1");
  end

  tx_state_t            state_q, state_d;
  logic                 txd_q, txd_d;
  logic [DataWidth-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shreg_shift;
  logic                 baud_tick;
  logic                 baud_restart;
  logic [BaudW-1:0]     baud_limit;

  // Pop only from idle, and never during a clear or reset, so no word is dropped.
  assign ack  = (state_q == IDLE) & en & ~empty & ~sclr & rst_n;
  assign txd  = txd_q;
  assign busy = (state_q != IDLE);

  // The counter is parked at zero while idle, so the start bit gets a full period.
  assign baud_restart = sclr | (state_q == IDLE);
  assign baud_limit   = (state_q == STOP) ? StopLimit : BitLimit;
  assign shreg_shift  = shreg_q >> 1;

  baud_gen #(
    .CntW (BaudW)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .limit   (baud_limit),
    .tick    (baud_tick)
  );

  // Next-state and line-level decode; sclr overrides any phase.
  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ack) begin
          shreg_d = q;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          txd_d     = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q < LastBit) begin
            shreg_d   = shreg_shift;
            txd_d     = shreg_shift[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            txd_d   = 1'b1;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sclr) begin
      state_d   = IDLE;
      txd_d     = 1'b1;
      bit_cnt_d = '0;
    end
  end

  // State, line and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      bit_cnt_q <= '0;
      // NOTE: the shift register is reset too; it is a single word, not a memory array.
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  // A pop always moves the block out of idle, so ack is a single-cycle pulse.
  a_ack_single : assert property (@(posedge clk) disable iff (!rst_n) ack |=> !ack);
  a_ack_busy   : assert property (@(posedge clk) disable iff (!rst_n) ack |=> busy);

endmodule

// File: tb/tb_sa_fifo_uart_tx.sv
// Bench: show-ahead FIFO model upstream, cycle-accurate line decoder and word scoreboard downstream.
module tb_sa_fifo_uart_tx;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int SB  = 1;
  localparam int FC  = frame_cycles(DW, DIV, SB);

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          sclr    = 1'b0;
  logic          en      = 1'b1;
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ack, txd, busy, fifo_empty;
  logic [DW-1:0] fifo_q;

  // Show-ahead FIFO model: cleared by sclr only, not by rst_n.
  logic [DW-1:0] fmem [16];
  logic [4:0]    wptr = '0;
  logic [4:0]    rptr = '0;
  assign fifo_empty = (wptr == rptr);
  assign fifo_q     = fmem[rptr[3:0]];

  always @(posedge clk) begin
    if (sclr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        fmem[wptr[3:0]] <= wr_data;
        wptr            <= wptr + 5'd1;
      end
      if (ack && !fifo_empty) rptr <= rptr + 5'd1;
    end
  end

  sa_fifo_uart_tx #(.DataWidth(DW), .ClkDiv(DIV), .StopBits(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .en    (en),
    .empty (fifo_empty),
    .q     (fifo_q),
    .ack   (ack),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Scoreboard of words in FIFO order, pushed when the bench writes them.
  logic [DW-1:0] sb [$];

  // Line level expected at frame cycle p for word w.
  function automatic logic line_level(input logic [DW-1:0] w, input int p);
    int b;
    b = p / DIV;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    return 1'b1;
  endfunction

  // Decoder state, sampled 1ns before every rising edge.
  bit            in_frame      = 0;
  int            pos           = 0;
  logic [DW-1:0] cur_word      = '0;
  logic [9:0]    cap           = '0;
  logic [9:0]    last_pattern  = '0;
  logic [DW-1:0] last_word     = '0;
  int            frames_done   = 0;
  int            busy_cnt      = 0;
  int            ack_cnt       = 0;
  int            last_ack      = 0;
  int            prev_ack      = 0;
  int            high_run      = 0;
  int            last_high_run = 0;
  int            cyc           = 0;

  always begin
    logic exp_ack;
    @(negedge clk);
    #4;
    cyc++;
    if (!rst_n) begin
      check("reset_txd", 32'(txd), 32'(1));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_ack", 32'(ack), 32'(0));
      in_frame = 0;
    end else begin
      exp_ack = !in_frame && en && !fifo_empty && !sclr;
      check("txd", 32'(txd), 32'(in_frame ? line_level(cur_word, pos) : 1'b1));
      check("busy", 32'(busy), 32'(in_frame));
      check("ack", 32'(ack), 32'(exp_ack));
      if (busy) busy_cnt++;
      if (ack) begin
        ack_cnt++;
        prev_ack = last_ack;
        last_ack = cyc;
      end
      if (txd) high_run++;
      else begin
        if (high_run > 0) last_high_run = high_run;
        high_run = 0;
      end
      if (in_frame && (pos % DIV) == DIV / 2) cap[pos / DIV] = txd;
      if (sclr) begin
        in_frame = 0;
        sb.delete();
      end else if (in_frame) begin
        if (pos == FC - 1) begin
          in_frame     = 0;
          frames_done++;
          last_pattern = cap;
          last_word    = cap[DW:1];
          check("decoded_word", 32'(cap[DW:1]), 32'(cur_word));
        end else begin
          pos++;
        end
      end else if (exp_ack) begin
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 32'(0), 32'(1));
        end else begin
          cur_word = sb.pop_front();
        end
        in_frame = 1;
        pos      = 0;
      end
    end
  end

  task automatic write_word(input logic [DW-1:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
    sb.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (frames_done < target) timeout("wait_frames");
  endtask

  task automatic wait_pos(input int p, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (in_frame && pos == p) return;
    end
    timeout("wait_pos");
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fifo_empty && !in_frame && !busy) return;
    end
    timeout("wait_idle");
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic [9:0]    line;   // levels in send order, bit 0 first
  } vec_t;

  vec_t vecs [4];

  initial begin
    int b0, a0, f0, writes, k;

    vecs[0] = '{word: 8'hA5, line: 10'h34A};
    vecs[1] = '{word: 8'h5A, line: 10'h2B4};
    vecs[2] = '{word: 8'h81, line: 10'h302};
    vecs[3] = '{word: 8'hC3, line: 10'h386};

    // 1: reset held 20 cycles with the FIFO empty and en high.
    #1 rst_n = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      b0 = busy_cnt;
      a0 = ack_cnt;
      f0 = frames_done;
      write_word(vecs[i].word);
      wait_frames(f0 + 1, 200);
      repeat (2) @(negedge clk);
      check("row_line", 32'(last_pattern), 32'(vecs[i].line));
      check("row_ack_cycles", 32'(ack_cnt - a0), 32'(1));
      check("row_busy_cycles", 32'(busy_cnt - b0), 32'(FC));
      check("row_fifo_empty", 32'(fifo_empty), 32'(1));
    end

    // 3: back-to-back 0x00 then 0xFF.
    f0 = frames_done;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h00; sb.push_back(8'h00);
    @(negedge clk);
    wr_data = 8'hFF; sb.push_back(8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    wait_frames(f0 + 2, 300);
    repeat (2) @(negedge clk);
    check("b2b_ack_gap", 32'(last_ack - prev_ack), 32'(41));
    check("b2b_last_word", 32'(last_word), 32'(8'hFF));
    check("b2b_high_gap", 32'(last_high_run), 32'(5));

    // 4: sclr aborts a 0x3C frame at frame cycle 15.
    f0 = frames_done;
    write_word(8'h3C);
    wait_pos(15, 100);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    #4;
    check("sclr_txd", 32'(txd), 32'(1));
    check("sclr_busy", 32'(busy), 32'(0));
    repeat (20) @(negedge clk);
    check("sclr_fifo_empty", 32'(fifo_empty), 32'(1));
    check("sclr_no_frame", 32'(frames_done - f0), 32'(0));
    // sclr while a word waits in the FIFO: no pop, word flushed.
    en = 1'b0;
    write_word(8'h66);
    en   = 1'b1;
    sclr = 1'b1;
    #4;
    check("sclr_blocks_ack", 32'(ack), 32'(0));
    @(negedge clk);
    sclr = 1'b0;
    #4;
    check("sclr_flushes", 32'(fifo_empty), 32'(1));
    check("sclr_idle_ack", 32'(ack), 32'(0));

    // 5: en gating of the pop; en dropped mid-frame does not stop it.
    @(negedge clk);
    en = 1'b0;
    f0 = frames_done;
    write_word(8'h12);
    a0 = ack_cnt;
    repeat (10) @(negedge clk);
    check("en_low_no_ack", 32'(ack_cnt - a0), 32'(0));
    en = 1'b1;
    #4;
    check("en_high_ack", 32'(ack), 32'(1));
    wait_pos(8, 100);
    en = 1'b0;
    wait_frames(f0 + 1, 200);
    repeat (2) @(negedge clk);
    check("en_drop_word", 32'(last_word), 32'(8'h12));
    check("en_drop_busy", 32'(busy), 32'(0));

    // 6: async reset mid-frame, then the remaining words.
    en = 1'b1;
    f0 = frames_done;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h81; sb.push_back(8'h81);
    @(negedge clk);
    wr_data = 8'h42; sb.push_back(8'h42);
    @(negedge clk);
    wr_data = 8'h7E; sb.push_back(8'h7E);
    @(negedge clk);
    wr_en = 1'b0;
    wait_pos(22, 100);
    rst_n = 1'b0;
    #4;
    check("async_rst_txd", 32'(txd), 32'(1));
    check("async_rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(400);
    check("rst_resume_frames", 32'(frames_done - f0), 32'(2));
    check("rst_resume_last", 32'(last_word), 32'(8'h7E));

    // Random traffic with random en and sclr.
    writes = 0;
    k      = 0;
    while (writes < 1000 && k < 80000) begin
      @(negedge clk);
      k++;
      sclr = ($urandom_range(149) == 0);
      en   = ($urandom_range(7) != 0);
      if (!sclr && 5'(wptr - rptr) < 5'd4 && $urandom_range(2) == 0) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        sb.push_back(wr_data);
        writes++;
      end else begin
        wr_en = 1'b0;
      end
    end
    if (writes < 1000) timeout("random_writes");
    @(negedge clk);
    wr_en = 1'b0;
    sclr  = 1'b0;
    en    = 1'b1;
    wait_idle(1000);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
